bsg_nonsynth_mem_1r1w_sync_req_adapter: RTL and testbench

- Front-end for a nonsynth 1r1w synchronous byte-masked memory with a one-cycle read-data latency.
- Accepts read/write request packets over valid/ready and drives the memory's separate read and write ports.
- Captures read data one cycle after issue and queues it in an in-order response FIFO, returned over valid/yumi.
- Credit accounting ensures a read is never issued without a guaranteed FIFO slot; used by testbench DMA/host models.

---
 rtl/bsg_nonsynth_mem_1r1w_sync_req_adapter.sv | 155 +++++++++++++++
 tb/tb_bsg_nonsynth_mem_1r1w_sync_req_adapter.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/bsg_nonsynth_mem_1r1w_sync_req_adapter.sv
// Request front-end for a nonsynthesizable 1r1w synchronous byte-masked memory.
// Read and write requests arrive over valid/ready and go straight to the memory ports.
// Read data returns one cycle after issue, is queued in an in-order response FIFO,
// and is handed back over valid/yumi. A credit check (queued + in flight) keeps a
// FIFO slot reserved for every read that is issued.

module bsg_nonsynth_mem_1r1w_sync_req_adapter #(
    parameter int width_p       = 32,
    parameter int els_p         = 16,
    parameter int resp_els_p    = 4,
    localparam int addr_width_lp = (els_p > 1) ? $clog2(els_p) : 1,
    localparam int mask_width_lp = width_p >> 3,
    localparam int cnt_width_lp  = $clog2(resp_els_p + 1),
    localparam int ptr_width_lp  = (resp_els_p > 1) ? $clog2(resp_els_p) : 1
) (
    input  logic                     clk_i,
    input  logic                     reset_i,

    input  logic                     v_i,
    input  logic                     w_i,
    input  logic [addr_width_lp-1:0] addr_i,
    input  logic [width_p-1:0]       data_i,
    input  logic [mask_width_lp-1:0] mask_i,
    output logic                     ready_o,

    output logic [width_p-1:0]       data_o,
    output logic                     v_o,
    input  logic                     yumi_i,

    output logic                     mem_r_v_o,
    output logic [addr_width_lp-1:0] mem_r_addr_o,
    output logic                     mem_w_v_o,
    output logic [addr_width_lp-1:0] mem_w_addr_o,
    output logic [width_p-1:0]       mem_w_data_o,
    output logic [mask_width_lp-1:0] mem_w_mask_o,
    input  logic [width_p-1:0]       mem_data_i
);

    localparam int sum_width_lp = cnt_width_lp + 1;

    // Advance a FIFO pointer, wrapping at resp_els_p (depth need not be a power of two).
    function automatic logic [ptr_width_lp-1:0] ptr_inc(input logic [ptr_width_lp-1:0] p);
        if (p == ptr_width_lp'(resp_els_p - 1)) begin
            return '0;
        end else begin
            return p + ptr_width_lp'(1);
        end
    endfunction

    logic                    r_pending;
    logic [cnt_width_lp-1:0] r_count;
    logic [ptr_width_lp-1:0] r_rd_ptr;
    logic [ptr_width_lp-1:0] r_wr_ptr;
    logic [width_p-1:0]      r_fifo [resp_els_p];

    logic                    w_credit_ok;
    logic                    w_ready;
    logic                    w_rd_fire;
    logic                    w_wr_fire;
    logic                    w_resp_v;
    logic                    w_deq;

    // Credit, handshake and response-side combinational decode; credit uses registered state only.
    always_comb begin
        w_credit_ok = (sum_width_lp'(r_count) + sum_width_lp'(r_pending))
                      < sum_width_lp'(resp_els_p);
        w_ready     = ~reset_i & w_credit_ok;
        w_rd_fire   = v_i & w_ready & ~w_i;
        w_wr_fire   = v_i & w_ready & w_i;
        w_resp_v    = ~reset_i & (r_count != cnt_width_lp'(0));
        w_deq       = yumi_i & w_resp_v;
    end

    // Drive handshake, response and memory-port outputs straight from the decode.
    always_comb begin
        ready_o      = w_ready;
        v_o          = w_resp_v;
        data_o       = r_fifo[r_rd_ptr];
        mem_r_v_o    = w_rd_fire;
        mem_r_addr_o = addr_i;
        mem_w_v_o    = w_wr_fire;
        mem_w_addr_o = addr_i;
        mem_w_data_o = data_i;
        mem_w_mask_o = mask_i;
    end

    // In-flight flag, FIFO pointers and occupancy; reset discards queued and in-flight reads.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_pending <= 1'b0;
            r_count   <= '0;
            r_rd_ptr  <= '0;
            r_wr_ptr  <= '0;
        end else begin
            r_pending <= w_rd_fire;
            if (r_pending) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end else begin
                r_wr_ptr <= r_wr_ptr;
            end
            if (w_deq) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end else begin
                r_rd_ptr <= r_rd_ptr;
            end
            r_count <= r_count + cnt_width_lp'(r_pending) - cnt_width_lp'(w_deq);
        end
    end

    // Capture memory read data into the FIFO in the cycle after the read was issued.
    always_ff @(posedge clk_i) begin
        if (!reset_i && r_pending) begin
            r_fifo[r_wr_ptr] <= mem_data_i;
        end
    end

`ifndef SYNTHESIS
    bsg_nonsynth_mem_1r1w_sync_req_adapter_checker #(
        .resp_els_p   (resp_els_p),
        .cnt_width_lp (cnt_width_lp)
    ) checker_inst (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .yumi_i    (yumi_i),
        .v_o       (w_resp_v),
        .count_i   (r_count),
        .pending_i (r_pending)
    );
`endif

endmodule

// Protocol and credit invariants for the request adapter.
module bsg_nonsynth_mem_1r1w_sync_req_adapter_checker #(
    parameter int resp_els_p   = 4,
    parameter int cnt_width_lp = 3
) (
    input logic                    clk_i,
    input logic                    reset_i,
    input logic                    yumi_i,
    input logic                    v_o,
    input logic [cnt_width_lp-1:0] count_i,
    input logic                    pending_i
);

    a_yumi_needs_valid: assert property (@(posedge clk_i) disable iff (reset_i)
        yumi_i |-> v_o)
        else $error("adapter: yumi_i asserted while v_o is low");

    a_credit_bound: assert property (@(posedge clk_i) disable iff (reset_i)
        ((cnt_width_lp + 1)'(count_i) + (cnt_width_lp + 1)'(pending_i))
            <= (cnt_width_lp + 1)'(resp_els_p))
        else $error("adapter: queued plus in-flight reads exceed FIFO depth");

endmodule

// File: tb/tb_bsg_nonsynth_mem_1r1w_sync_req_adapter.sv
// Directed bench for the 1r1w request adapter: a cycle-by-cycle vector table
// plus a back-to-back read stream with automatic consumption.
`timescale 1ns/1ps

module tb_bsg_nonsynth_mem_1r1w_sync_req_adapter;

    logic        clk;
    logic        rst;
    logic        v_in;
    logic        w_in;
    logic [3:0]  addr_in;
    logic [31:0] data_in;
    logic [3:0]  mask_in;
    logic        ready;
    logic [31:0] data_out;
    logic        v_out;
    logic        yumi;
    logic        yumi_drv;
    logic        yumi_auto;
    logic        mem_r_v;
    logic [3:0]  mem_r_addr;
    logic        mem_w_v;
    logic [3:0]  mem_w_addr;
    logic [31:0] mem_w_data;
    logic [3:0]  mem_w_mask;
    logic [31:0] mem_rdata;
    logic [31:0] mem [16];

    int tests;
    int fails;

    assign yumi = yumi_drv | (yumi_auto & v_out);

    bsg_nonsynth_mem_1r1w_sync_req_adapter #(
        .width_p    (32),
        .els_p      (16),
        .resp_els_p (4)
    ) dut (
        .clk_i        (clk),
        .reset_i      (rst),
        .v_i          (v_in),
        .w_i          (w_in),
        .addr_i       (addr_in),
        .data_i       (data_in),
        .mask_i       (mask_in),
        .ready_o      (ready),
        .data_o       (data_out),
        .v_o          (v_out),
        .yumi_i       (yumi),
        .mem_r_v_o    (mem_r_v),
        .mem_r_addr_o (mem_r_addr),
        .mem_w_v_o    (mem_w_v),
        .mem_w_addr_o (mem_w_addr),
        .mem_w_data_o (mem_w_data),
        .mem_w_mask_o (mem_w_mask),
        .mem_data_i   (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous byte-masked memory with one-cycle read latency; reset reloads a known pattern.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) mem[i] <= 32'h1000_0000 + i;
        end else if (mem_w_v) begin
            for (int b = 0; b < 4; b++)
                if (mem_w_mask[b]) mem[mem_w_addr][8*b +: 8] <= mem_w_data[8*b +: 8];
        end
        if (mem_r_v) mem_rdata <= mem[mem_r_addr];
    end

    typedef struct {
        logic        rst;
        logic        v;
        logic        w;
        logic [3:0]  addr;
        logic [31:0] data;
        logic [3:0]  mask;
        logic        yumi;
        logic        e_ready;
        logic        e_v;
        logic        e_rv;
        logic        e_wv;
        logic [31:0] e_data;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic v, input logic w, input logic [3:0] a,
                       input logic [31:0] d, input logic [3:0] m, input logic y,
                       input logic er, input logic ev, input logic erv, input logic ewv,
                       input logic [31:0] ed);
        vec_t t;
        t.rst = r; t.v = v; t.w = w; t.addr = a; t.data = d; t.mask = m; t.yumi = y;
        t.e_ready = er; t.e_v = ev; t.e_rv = erv; t.e_wv = ewv; t.e_data = ed;
        vecs.push_back(t);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    initial begin
        tests = 0; fails = 0;
        rst = 1'b1; v_in = 1'b0; w_in = 1'b0; addr_in = 4'd0; data_in = 32'd0;
        mask_in = 4'd0; yumi_drv = 1'b0; yumi_auto = 1'b0;

        //   rst   v     w     addr   data            mask   yumi | rdy  v_o  rv    wv    data_o
        // reset held, requests during reset must not reach memory
        add(1'b1, 1'b0, 1'b0, 4'd0, 32'h0,          4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        add(1'b1, 1'b1, 1'b1, 4'd2, 32'h55,         4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        add(1'b1, 1'b1, 1'b0, 4'd2, 32'h0,          4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        add(1'b0, 1'b0, 1'b0, 4'd0, 32'h0,          4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        // full write then read: response two cycles after handshake
        add(1'b0, 1'b1, 1'b1, 4'd5, 32'hDEADBEEF,   4'hF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0);
        add(1'b0, 1'b1, 1'b0, 4'd5, 32'h0,          4'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        add(1'b0, 1'b0, 1'b0, 4'd0, 32'h0,          4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        add(1'b0, 1'b0, 1'b0, 4'd0, 32'h0,          4'h0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'hDEADBEEF);
        add(1'b0, 1'b0, 1'b0, 4'd0, 32'h0,          4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        // partial byte mask merge
        add(1'b0, 1'b1, 1'b1, 4'd3, 32'h11223344,   4'hF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0);
        add(1'b0, 1'b1, 1'b1, 4'd3, 32'hAABBCCDD,   4'h5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0);
        add(1'b0, 1'b1, 1'b0, 4'd3, 32'h0,          4'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        add(1'b0, 1'b0, 1'b0, 4'd0, 32'h0,          4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        add(1'b0, 1'b0, 1'b0, 4'd0, 32'h0,          4'h0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h11BB33DD);
        add(1'b0, 1'b0, 1'b0, 4'd0, 32'h0,          4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        // backpressure: stream reads with no consumption, 4 accepted
        add(1'b0, 1'b1, 1'b0, 4'd0, 32'h0,          4'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        add(1'b0, 1'b1, 1'b0, 4'd1, 32'h0,          4'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        add(1'b0, 1'b1, 1'b0, 4'd2, 32'h0,          4'h0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h10000000);
        add(1'b0, 1'b1, 1'b0, 4'd3, 32'h0,          4'h0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h10000000);
        add(1'b0, 1'b1, 1'b0, 4'd4, 32'h0,          4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h10000000);
        add(1'b0, 1'b1, 1'b0, 4'd4, 32'h0,          4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h10000000);
        add(1'b0, 1'b1, 1'b0, 4'd4, 32'h0,          4'h0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h10000001);
        add(1'b0, 1'b0, 1'b0, 4'd0, 32'h0,          4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h10000001);
        add(1'b0, 1'b0, 1'b0, 4'd0, 32'h0,          4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h10000001);
        add(1'b0, 1'b0, 1'b0, 4'd0, 32'h0,          4'h0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h10000002);
        add(1'b0, 1'b0, 1'b0, 4'd0, 32'h0,          4'h0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h11BB33DD);
        add(1'b0, 1'b0, 1'b0, 4'd0, 32'h0,          4'h0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h10000004);
        add(1'b0, 1'b0, 1'b0, 4'd0, 32'h0,          4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        // reset with 2 queued and 1 in flight, then a fresh read
        add(1'b0, 1'b1, 1'b0, 4'd6, 32'h0,          4'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        add(1'b0, 1'b1, 1'b0, 4'd7, 32'h0,          4'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        add(1'b0, 1'b1, 1'b0, 4'd8, 32'h0,          4'h0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h10000006);
        add(1'b1, 1'b0, 1'b0, 4'd0, 32'h0,          4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        add(1'b0, 1'b0, 1'b0, 4'd0, 32'h0,          4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        add(1'b0, 1'b1, 1'b0, 4'd9, 32'h0,          4'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        add(1'b0, 1'b0, 1'b0, 4'd0, 32'h0,          4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        add(1'b0, 1'b0, 1'b0, 4'd0, 32'h0,          4'h0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h10000009);
        add(1'b0, 1'b0, 1'b0, 4'd0, 32'h0,          4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst = vecs[i].rst; v_in = vecs[i].v; w_in = vecs[i].w; addr_in = vecs[i].addr;
            data_in = vecs[i].data; mask_in = vecs[i].mask; yumi_drv = vecs[i].yumi;
            #1;
            chk($sformatf("row%0d ready", i),    {31'd0, ready},   {31'd0, vecs[i].e_ready});
            chk($sformatf("row%0d v_o", i),      {31'd0, v_out},   {31'd0, vecs[i].e_v});
            chk($sformatf("row%0d mem_r_v", i),  {31'd0, mem_r_v}, {31'd0, vecs[i].e_rv});
            chk($sformatf("row%0d mem_w_v", i),  {31'd0, mem_w_v}, {31'd0, vecs[i].e_wv});
            if (vecs[i].e_v)
                chk($sformatf("row%0d data_o", i), data_out, vecs[i].e_data);
            if (vecs[i].e_rv)
                chk($sformatf("row%0d mem_r_addr", i), {28'd0, mem_r_addr}, {28'd0, vecs[i].addr});
            if (vecs[i].e_wv) begin
                chk($sformatf("row%0d mem_w_addr", i), {28'd0, mem_w_addr}, {28'd0, vecs[i].addr});
                chk($sformatf("row%0d mem_w_data", i), mem_w_data, vecs[i].data);
                chk($sformatf("row%0d mem_w_mask", i), {28'd0, mem_w_mask}, {28'd0, vecs[i].mask});
            end
        end

        // Full throughput: 20 back-to-back reads, responses consumed as soon as valid.
        @(negedge clk);
        rst = 1'b0; v_in = 1'b0; w_in = 1'b0; yumi_drv = 1'b0; yumi_auto = 1'b1;
        for (int k = 0; k < 23; k++) begin
            @(negedge clk);
            v_in = (k < 20); w_in = 1'b0; addr_in = 4'(k % 16);
            #1;
            if (k < 20)
                chk($sformatf("stream%0d ready", k), {31'd0, ready}, 32'd1);
            if (k >= 2 && k < 22) begin
                chk($sformatf("stream%0d v_o", k), {31'd0, v_out}, 32'd1);
                chk($sformatf("stream%0d data_o", k), data_out, 32'h1000_0000 + ((k - 2) % 16));
            end else begin
                chk($sformatf("stream%0d v_o idle", k), {31'd0, v_out}, 32'd0);
            end
        end
        @(negedge clk);
        v_in = 1'b0; yumi_auto = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
